// File: rtl/csr_mtrap_pkg.sv
// Shared constants for the machine-mode trap CSR file: CSR addresses, field
// bit positions, reset values and the address-decode helper.
package csr_mtrap_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned CNT_W  = 64;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH= 12'hB82;
    localparam logic [11:0] CSR_DCSR     = 12'h7B0;
    localparam logic [11:0] CSR_DPC      = 12'h7B1;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // mstatus fields
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;

    // mie / mip bit positions
    localparam int unsigned IRQ_MSI = 3;
    localparam int unsigned IRQ_MTI = 7;
    localparam int unsigned IRQ_MEI = 11;

    // dcsr: xdebugver is a constant 4 in bits 31:28, cause lives in 8:6
    localparam logic [3:0]  DCSR_XDEBUGVER = 4'd4;
    localparam int unsigned DCSR_CAUSE_LO  = 6;

    // True for every implemented CSR address
    function automatic logic csr_mapped(input logic [11:0] idx);
        case (idx)
            CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL, CSR_MIP,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
            CSR_DCSR, CSR_DPC, CSR_MHARTID: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr_mtrap_cnt64.sv
// 64-bit free-running counter with half-word overwrite.
// Ports: clk, rst (async, active-high), inc_i (count enable), wr_lo_i /
// wr_hi_i (replace low / high half with wdata_i), cnt_o (current value).
module csr_cnt64
    import csr_mtrap_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              wr_lo_i,
    input  logic              wr_hi_i,
    input  logic [XLEN_W-1:0] wdata_i,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A write to either half suppresses the increment for that cycle
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[XLEN_W-1:0]     = wdata_i;
            if (wr_hi_i) cnt_d[CNT_W-1:XLEN_W] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_mtrap.sv
// Machine-mode trap CSR file downstream of the exception/commit unit.
// Ports: clk, rst_n (async, ACTIVE-HIGH), ALU CSR port (csr_ena/wr/rd,
// csr_idx, wbck_csr_dat -> read_csr_dat, csr_access_ilgl, both comb),
// commit strobes (cmt_*), interrupt levels (*_irq_r), and registered
// feedback to the exception unit (mtvec, mepc, dpc, enable bits).
module csr_mtrap
    import csr_mtrap_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] HARTID   = 32'h0,
    parameter logic [31:0] MISA_VAL = 32'h4000_1104
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_ena,
    input  logic            csr_wr_en,
    input  logic            csr_rd_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] wbck_csr_dat,
    output logic [XLEN-1:0] read_csr_dat,
    output logic            csr_access_ilgl,
    input  logic [XLEN-1:0] cmt_epc,
    input  logic [XLEN-1:0] cmt_cause,
    input  logic [XLEN-1:0] cmt_badaddr,
    input  logic            cmt_epc_ena,
    input  logic            cmt_cause_ena,
    input  logic            cmt_badaddr_ena,
    input  logic            cmt_status_ena,
    input  logic [XLEN-1:0] cmt_dpc,
    input  logic            cmt_dpc_ena,
    input  logic [2:0]      cmt_dcause,
    input  logic            cmt_dcause_ena,
    input  logic            cmt_mret_ena,
    input  logic            cmt_instret_ena,
    input  logic            ext_irq_r,
    input  logic            sft_irq_r,
    input  logic            tmr_irq_r,
    output logic [XLEN-1:0] csr_mtvec_r,
    output logic [XLEN-1:0] csr_epc_r,
    output logic [XLEN-1:0] csr_dpc_r,
    output logic            status_mie_r,
    output logic            meie_r,
    output logic            mtie_r,
    output logic            msie_r
);

    logic            mie_q, mie_d, mpie_q, mpie_d;
    logic            msie_q, msie_d, mtie_q, mtie_d, meie_q, meie_d;
    logic [2:0]      mip_q, mip_d;   // {MEI, MTI, MSI}
    logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [XLEN-1:0] dpc_q, dpc_d;
    logic [27:0]     dcsr_q, dcsr_d; // xdebugver is not stored
    logic [63:0]     mcycle, minstret;
    logic [XLEN-1:0] rdata;
    logic            wr_ok;

    assign csr_access_ilgl = csr_ena &
        (~csr_mapped(csr_idx) | (csr_wr_en & (csr_idx[11:10] == 2'b11)));
    assign wr_ok = csr_ena & csr_wr_en & ~csr_access_ilgl;

    // Next-state: commit strobes beat mret, which beats a CSR write
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        msie_d     = msie_q;
        mtie_d     = mtie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        dpc_d      = dpc_q;
        dcsr_d     = dcsr_q;
        mip_d      = {ext_irq_r, tmr_irq_r, sft_irq_r};

        if (cmt_status_ena) begin
            mpie_d = mie_q;
            mie_d  = 1'b0;
        end else if (cmt_mret_ena) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_ok && csr_idx == CSR_MSTATUS) begin
            mie_d  = wbck_csr_dat[MSTATUS_MIE];
            mpie_d = wbck_csr_dat[MSTATUS_MPIE];
        end

        if (wr_ok && csr_idx == CSR_MIE) begin
            msie_d = wbck_csr_dat[IRQ_MSI];
            mtie_d = wbck_csr_dat[IRQ_MTI];
            meie_d = wbck_csr_dat[IRQ_MEI];
        end

        if (wr_ok && csr_idx == CSR_MTVEC)    mtvec_d    = wbck_csr_dat & ~XLEN'(3);
        if (wr_ok && csr_idx == CSR_MSCRATCH) mscratch_d = wbck_csr_dat;

        if (cmt_epc_ena)                           mepc_d = cmt_epc & ~XLEN'(1);
        else if (wr_ok && csr_idx == CSR_MEPC)     mepc_d = wbck_csr_dat & ~XLEN'(1);

        if (cmt_cause_ena)                         mcause_d = cmt_cause;
        else if (wr_ok && csr_idx == CSR_MCAUSE)   mcause_d = wbck_csr_dat;

        if (cmt_badaddr_ena)                       mtval_d = cmt_badaddr;
        else if (wr_ok && csr_idx == CSR_MTVAL)    mtval_d = wbck_csr_dat;

        if (cmt_dpc_ena)                           dpc_d = cmt_dpc;
        else if (wr_ok && csr_idx == CSR_DPC)      dpc_d = wbck_csr_dat;

        if (cmt_dcause_ena)                        dcsr_d[DCSR_CAUSE_LO +: 3] = cmt_dcause;
        else if (wr_ok && csr_idx == CSR_DCSR)     dcsr_d = wbck_csr_dat[27:0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            msie_q     <= 1'b0;
            mtie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mip_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            dpc_q      <= '0;
            dcsr_q     <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            msie_q     <= msie_d;
            mtie_q     <= mtie_d;
            meie_q     <= meie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            dpc_q      <= dpc_d;
            dcsr_q     <= dcsr_d;
        end
    end

    csr_cnt64 u_mcycle (
        .clk     (clk),
        .rst     (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (wr_ok && csr_idx == CSR_MCYCLE),
        .wr_hi_i (wr_ok && csr_idx == CSR_MCYCLEH),
        .wdata_i (wbck_csr_dat),
        .cnt_o   (mcycle)
    );

    csr_cnt64 u_minstret (
        .clk     (clk),
        .rst     (rst_n),
        .inc_i   (cmt_instret_ena),
        .wr_lo_i (wr_ok && csr_idx == CSR_MINSTRET),
        .wr_hi_i (wr_ok && csr_idx == CSR_MINSTRETH),
        .wdata_i (wbck_csr_dat),
        .cnt_o   (minstret)
    );

    // Read mux; MPP is hardwired to machine mode
    always_comb begin
        rdata = '0;
        case (csr_idx)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]         = mie_q;
                rdata[MSTATUS_MPIE]        = mpie_q;
                rdata[MSTATUS_MPP_LO +: 2] = 2'b11;
            end
            CSR_MISA:      rdata = MISA_VAL;
            CSR_MIE: begin
                rdata[IRQ_MSI] = msie_q;
                rdata[IRQ_MTI] = mtie_q;
                rdata[IRQ_MEI] = meie_q;
            end
            CSR_MTVEC:     rdata = mtvec_q;
            CSR_MSCRATCH:  rdata = mscratch_q;
            CSR_MEPC:      rdata = mepc_q;
            CSR_MCAUSE:    rdata = mcause_q;
            CSR_MTVAL:     rdata = mtval_q;
            CSR_MIP: begin
                rdata[IRQ_MSI] = mip_q[0];
                rdata[IRQ_MTI] = mip_q[1];
                rdata[IRQ_MEI] = mip_q[2];
            end
            CSR_MCYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH: rdata = minstret[63:32];
            CSR_DCSR:      rdata = {DCSR_XDEBUGVER, dcsr_q};
            CSR_DPC:       rdata = dpc_q;
            CSR_MHARTID:   rdata = HARTID;
            default:       rdata = '0;
        endcase
    end

    assign read_csr_dat = (csr_ena & csr_rd_en & ~csr_access_ilgl) ? rdata : '0;

    assign csr_mtvec_r  = mtvec_q;
    assign csr_epc_r    = mepc_q;
    assign csr_dpc_r    = dpc_q;
    assign status_mie_r = mie_q;
    assign meie_r       = meie_q;
    assign mtie_r       = mtie_q;
    assign msie_r       = msie_q;

endmodule
